// File: rtl/pr_read_arbiter.sv
// pr_read_arbiter
// Shares one AXI read channel (AR + R) between two PageRank read requesters:
// requester 0 is the vertex-array fetcher and requester 1 is the in-edge
// fetcher. AR requests are granted round-robin and tagged with the requester
// index on arid_m. Returning R beats are steered back to the owner by rid_m.
// A per-requester count of outstanding beats stops a requester from asking
// for more data than its destination buffer can hold.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rqN_arvalid/araddr/arlen      request from requester N (N = 0, 1)
//   rqN_arready                   single-cycle grant pulse to requester N
//   rqN_rvalid/rdata/rlast        R beat delivered to requester N
//   rqN_rready                    requester N can take a beat
//   arid_m..arready_m             AXI AR channel towards the shell
//   rid_m..rready_m               AXI R channel from the shell
//   busy                          AR pending or beats still outstanding
//   err                           sticky: unknown rid, bad rresp, underflow
module pr_read_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         rq0_arvalid,
    input  logic [63:0]  rq0_araddr,
    input  logic [7:0]   rq0_arlen,
    output logic         rq0_arready,
    output logic         rq0_rvalid,
    output logic [511:0] rq0_rdata,
    output logic         rq0_rlast,
    input  logic         rq0_rready,

    input  logic         rq1_arvalid,
    input  logic [63:0]  rq1_araddr,
    input  logic [7:0]   rq1_arlen,
    output logic         rq1_arready,
    output logic         rq1_rvalid,
    output logic [511:0] rq1_rdata,
    output logic         rq1_rlast,
    input  logic         rq1_rready,

    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,

    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m,

    output logic         busy,
    output logic         err
);

    // Wide enough that out + arlen + 1 can never wrap.
    localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 2;

    logic [CNT_W-1:0] out0, out1;
    logic [CNT_W-1:0] out0_next, out1_next;
    logic             last_gnt;
    logic [SUM_W-1:0] need0, need1;
    logic             elig0, elig1;
    logic             ar_free;
    logic             gnt0, gnt1;
    logic             arvalid_next;
    logic             rid_is0, rid_is1;
    logic             beat0, beat1;
    logic             err_next;

    assign arsize_m = 3'b110;

    // A requester may only ask for beats that still fit in its buffer,
    // judged against the registered count.
    assign need0 = SUM_W'(out0) + SUM_W'(rq0_arlen) + SUM_W'(1);
    assign need1 = SUM_W'(out1) + SUM_W'(rq1_arlen) + SUM_W'(1);
    assign elig0 = rq0_arvalid && (need0 <= SUM_W'(MAX_BEATS));
    assign elig1 = rq1_arvalid && (need1 <= SUM_W'(MAX_BEATS));

    // The AR register can take a new request when empty or being emptied
    // this very cycle, which gives back-to-back grants.
    assign ar_free = !arvalid_m || arready_m;

    // On a tie the requester that did not win last time goes first.
    assign gnt0 = ar_free && elig0 && (!elig1 || last_gnt);
    assign gnt1 = ar_free && elig1 && (!elig0 || !last_gnt);

    assign rq0_arready = gnt0;
    assign rq1_arready = gnt1;

    // R steering is purely combinational; beats with an unknown id are
    // always accepted so they cannot stall the channel.
    assign rid_is0    = (rid_m == 16'd0);
    assign rid_is1    = (rid_m == 16'd1);
    assign rq0_rvalid = rvalid_m && rid_is0;
    assign rq1_rvalid = rvalid_m && rid_is1;
    assign rq0_rdata  = rdata_m;
    assign rq1_rdata  = rdata_m;
    assign rq0_rlast  = rlast_m;
    assign rq1_rlast  = rlast_m;
    assign rready_m   = rid_is0 ? rq0_rready : (rid_is1 ? rq1_rready : 1'b1);

    assign beat0 = rvalid_m && rready_m && rid_is0;
    assign beat1 = rvalid_m && rready_m && rid_is1;

    // Next values of the counters, AR valid and error flag. A beat arriving
    // at a zero count is flagged and the counter stays at zero instead of
    // wrapping. Truncating arlen+1 is safe because eligibility keeps the
    // total at or below MAX_BEATS.
    always_comb begin
        out0_next    = out0;
        out1_next    = out1;
        arvalid_next = arvalid_m && !arready_m;
        err_next     = err;

        if (gnt0) begin
            out0_next = out0_next + CNT_W'(rq0_arlen) + CNT_W'(1);
        end
        if (beat0 && (out0 != '0)) begin
            out0_next = out0_next - CNT_W'(1);
        end
        if (gnt1) begin
            out1_next = out1_next + CNT_W'(rq1_arlen) + CNT_W'(1);
        end
        if (beat1 && (out1 != '0)) begin
            out1_next = out1_next - CNT_W'(1);
        end

        if (gnt0 || gnt1) begin
            arvalid_next = 1'b1;
        end

        if (rvalid_m && !rid_is0 && !rid_is1) begin
            err_next = 1'b1;
        end
        if (rvalid_m && rready_m && (rresp_m != 2'b00)) begin
            err_next = 1'b1;
        end
        if ((beat0 && (out0 == '0)) || (beat1 && (out1 == '0))) begin
            err_next = 1'b1;
        end
    end

    // State register. busy is registered from the next-state values so it
    // always reflects the AR register and counters currently held.
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_m <= 1'b0;
            arid_m    <= '0;
            araddr_m  <= '0;
            arlen_m   <= '0;
            out0      <= '0;
            out1      <= '0;
            last_gnt  <= 1'b1;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            arvalid_m <= arvalid_next;
            out0      <= out0_next;
            out1      <= out1_next;
            err       <= err_next;
            busy      <= arvalid_next || (out0_next != '0) || (out1_next != '0);
            if (gnt0) begin
                arid_m   <= 16'd0;
                araddr_m <= rq0_araddr;
                arlen_m  <= rq0_arlen;
                last_gnt <= 1'b0;
            end else if (gnt1) begin
                arid_m   <= 16'd1;
                araddr_m <= rq1_araddr;
                arlen_m  <= rq1_arlen;
                last_gnt <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pr_read_arbiter.md
# pr_read_arbiter

Shares the single AXI read-address/read-data channel of the PageRank accelerator between two read requesters: requester 0 is the vertex-array fetcher and requester 1 is the in-edge fetcher. The arbiter grants AR requests round-robin, tags each request with its requester index on `arid_m`, and limits outstanding beats per requester so that downstream buffers never overflow. It routes returning R beats back to the owning requester by `rid_m`. It sits between the PageRank top-level fetch sequencer and the shell memory port.

## Interface
- `MAX_BEATS`, default 16: maximum in-flight read beats per requester, matching the destination buffer depth.
- `CNT_W`, default 5: width of the outstanding-beat counters; must satisfy 2^CNT_W > `MAX_BEATS`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rqN_arvalid` in 1 (N=0,1): requester N has a request pending.
- `rqN_araddr` in 64: byte address, 64-byte aligned.
- `rqN_arlen` in 8: beats minus one.
- `rqN_arready` out 1: single-cycle grant pulse; the request is consumed this cycle.
- `rqN_rvalid` out 1: R beat for requester N.
- `rqN_rdata` out 512: copy of `rdata_m`.
- `rqN_rlast` out 1: copy of `rlast_m`.
- `rqN_rready` in 1: requester N can accept a beat.
- `arid_m` out 16, `araddr_m` out 64, `arlen_m` out 8, `arsize_m` out 3, `arvalid_m` out 1, `arready_m` in 1: AXI AR channel.
- `rid_m` in 16, `rdata_m` in 512, `rresp_m` in 2, `rlast_m` in 1, `rvalid_m` in 1, `rready_m` out 1: AXI R channel.
- `busy` out 1: high while `arvalid_m` is high or either outstanding counter is non-zero.
- `err` out 1: sticky flag; set on an unknown `rid_m`, a non-zero `rresp_m`, or a counter underflow.

## Operation
- **AR output register:** holds `arid_m`, `araddr_m`, `arlen_m` and `arvalid_m`.
  - The register is free when `arvalid_m`=0, or when `arvalid_m & arready_m` is true in the current cycle.
  - While `arvalid_m`=1 and `arready_m`=0, all AR outputs hold stable.
- **Eligibility:** requester N is eligible when `rqN_arvalid`=1 and `outN + rqN_arlen + 1 <= MAX_BEATS`. The sum is computed at 9+ bits, so it does not wrap.
- **Grant:** occurs only when the AR register is free.
  - If both requesters are eligible, grant the one not granted last (`last_gnt` pointer).
  - If one is eligible, grant it.
  - On a grant: pulse `rqN_arready`, load the register with `arid_m`=N, the requester's address and length, and `arvalid_m`=1; set `last_gnt`=N.
- **Request loss:** a requester that is not granted keeps its request; the arbiter never drops an unacknowledged request.
- **Fixed AR field:** `arsize_m` = 3'b110 (64 bytes) at all times.
- **Outstanding counters `out0`, `out1`:**
  - On a grant to N: add `arlen+1`.
  - On each accepted R beat (`rvalid_m & rready_m`) with `rid_m`=N: subtract 1.
  - If both happen in the same cycle: net change is `arlen`.
- **R routing:**
  - `rqN_rvalid` = `rvalid_m & (rid_m==N)`.
  - `rready_m` = `rq0_rready` when `rid_m`=0, `rq1_rready` when `rid_m`=1, otherwise 1.
  - A beat with an unknown `rid_m` is drained and sets `err`.
- **Underflow:** a beat for requester N while `outN`=0 sets `err`; the counter saturates at 0.
- **Reset values:** `arvalid_m`=0, `arid_m`=0, `araddr_m`=0, `arlen_m`=0, `out0`=`out1`=0, `last_gnt`=1 (requester 0 wins the first tie), `err`=0, `busy`=0.
- **Reset mid-operation:** clears all state immediately. In-flight beats that return after reset underflow and set `err`; the top level is responsible for draining before reset.

## Timing
- Grant to `arvalid_m`: 1 cycle. `rqN_arready` and the register load happen on the same edge.
- AR throughput: one grant per cycle while `arready_m` stays high (back-to-back, with the register freed and reloaded in the same cycle).
- R path: combinational; zero added latency from `rvalid_m` to `rqN_rvalid` and from `rqN_rready` to `rready_m`.
- A counter decrement takes effect on the cycle after the beat, so eligibility uses the registered count and is one cycle conservative.
- `busy` and `err` are registered.

## Test plan
- **Single requester:** `rq0` requests addr 0x40, arlen 0, with `arready_m`=1 → `rq0_arready` pulses at cycle t, and `arvalid_m`=1, `arid_m`=0, `araddr_m`=0x40 at t+1. One R beat with `rid_m`=0 → `rq0_rvalid`=1, `out0` returns to 0, `busy` falls.
- **Round-robin:** both requesters hold requests continuously with `arready_m`=1 → grants alternate 0,1,0,1. The first grant after reset goes to 0.
- **Backpressure:** `arready_m`=0 for 5 cycles with `arvalid_m`=1 → the AR fields stay constant, and no further `rqN_arready` pulse occurs until the handshake completes.
- **Credit limit:** `MAX_BEATS`=16; `rq1` issues arlen 7 twice → `out1`=16, and a third request is blocked. After one beat returns (`out1`=15), a request with arlen 0 is granted and one with arlen 7 is not. A simultaneous grant and beat yields `out1` += arlen.
- **R routing with backpressure:** a beat with `rid_m`=1 while `rq1_rready`=0 → `rready_m`=0 and `out1` is unchanged. A beat with `rid_m`=0 in the next cycle is routed only to `rq0`.
- **Error cases:** `rid_m`=3 beat → `rready_m`=1 and `err` is set, staying set until `rst`. A beat for `rid_m`=0 with `out0`=0 → `err` is set and `out0` stays 0.
